// File: rtl/commit_trace_player.sv
// Table-driven commit-stream generator: replays preloaded commit records onto the
// commit channel with valid/ready backpressure, programmable gaps, looping and abort.
module commit_trace_player #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH),
   parameter int GAP_W = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_we,
   input  logic [IDX_W-1:0] ld_idx,
   input  logic [XLEN-1:0]  ld_pc,
   input  logic [31:0]      ld_instr,
   input  logic [4:0]       ld_rd,
   input  logic [XLEN-1:0]  ld_rd_data,
   input  logic             ld_mem_we,
   input  logic [XLEN-1:0]  ld_mem_addr,
   input  logic [XLEN-1:0]  ld_mem_wdata,
   input  logic             ld_trap,
   input  logic [IDX_W:0]   num_entries,
   input  logic [GAP_W-1:0] gap_cycles,
   input  logic             loop_en,
   input  logic [1:0]       priv_mode,
   input  logic             start,
   input  logic             abort,
   output logic             cmt_valid,
   input  logic             cmt_ready,
   output logic [XLEN-1:0]  cmt_pc,
   output logic [31:0]      cmt_instr,
   output logic [4:0]       cmt_rd_addr,
   output logic [XLEN-1:0]  cmt_rd_data,
   output logic             cmt_mem_we,
   output logic [XLEN-1:0]  cmt_mem_addr,
   output logic [XLEN-1:0]  cmt_mem_wdata,
   output logic             cmt_trap,
   output logic [1:0]       cmt_priv,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] commit_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [4:0]      rd;
      logic [XLEN-1:0] rd_data;
      logic            mem_we;
      logic [XLEN-1:0] mem_addr;
      logic [XLEN-1:0] mem_wdata;
      logic            trap;
   } rec_t;

   localparam logic [IDX_W:0]   DEPTH_L = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]   LEN_ONE = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Store fields are only meaningful on stores; zero them so the monitor sees clean data.
   function automatic rec_t mask_rec(input rec_t r);
      rec_t m;
      m = r;
      if (!r.mem_we) begin
         m.mem_addr  = '0;
         m.mem_wdata = '0;
      end
      return m;
   endfunction

   rec_t             tbl_q [DEPTH];
   state_t           state_q;
   logic             valid_q;
   logic             done_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W:0]   len_q;
   logic [GAP_W-1:0] gap_cfg_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic             loop_q;
   logic [1:0]       priv_q;
   rec_t             pl_q;

   logic             idle_like;
   logic             hs;
   logic             last;
   logic [IDX_W-1:0] idx_d;
   logic [IDX_W:0]   len_d;
   logic             start_ok;

   always_comb begin
      idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
      hs        = valid_q && cmt_ready;
      last      = ({1'b0, idx_q} == (len_q - LEN_ONE));
      idx_d     = last ? '0 : idx_q + IDX_ONE;
      len_d     = (num_entries > DEPTH_L) ? DEPTH_L : num_entries;
      start_ok  = start && idle_like && (len_d != '0);
   end

   // Table is loaded only while playback is stopped so emitted records never tear.
   always_ff @(posedge clk) begin
      if (ld_we && idle_like) begin
         tbl_q[ld_idx] <= '{pc:        ld_pc,
                            instr:     ld_instr,
                            rd:        ld_rd,
                            rd_data:   ld_rd_data,
                            mem_we:    ld_mem_we,
                            mem_addr:  ld_mem_addr,
                            mem_wdata: ld_mem_wdata,
                            trap:      ld_trap};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         gap_cfg_q <= '0;
         gap_cnt_q <= '0;
         loop_q    <= 1'b0;
         priv_q    <= '0;
         pl_q      <= '0;
      end else begin
         // A handshake coinciding with abort is still counted.
         if (hs) begin
            cnt_q <= cnt_q + CNT_ONE;
         end
         if (abort) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            gap_cnt_q <= '0;
         end else begin
            unique case (state_q)
               S_IDLE, S_DONE: begin
                  if (start_ok) begin
                     len_q     <= len_d;
                     gap_cfg_q <= gap_cycles;
                     loop_q    <= loop_en;
                     priv_q    <= priv_mode;
                     done_q    <= 1'b0;
                     cnt_q     <= '0;
                     idx_q     <= '0;
                     pl_q      <= mask_rec(tbl_q[0]);
                     valid_q   <= 1'b1;
                     state_q   <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (hs) begin
                     idx_q <= idx_d;
                     if (last && !loop_q) begin
                        state_q <= S_DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                     end else if (gap_cfg_q != '0) begin
                        state_q   <= S_GAP;
                        valid_q   <= 1'b0;
                        gap_cnt_q <= gap_cfg_q;
                     end else begin
                        pl_q <= mask_rec(tbl_q[idx_d]);
                     end
                  end
               end
               S_GAP: begin
                  if (gap_cnt_q <= GAP_ONE) begin
                     state_q   <= S_ISSUE;
                     valid_q   <= 1'b1;
                     gap_cnt_q <= '0;
                     pl_q      <= mask_rec(tbl_q[idx_q]);
                  end else begin
                     gap_cnt_q <= gap_cnt_q - GAP_ONE;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cmt_valid     = valid_q;
   assign cmt_pc        = pl_q.pc;
   assign cmt_instr     = pl_q.instr;
   assign cmt_rd_addr   = pl_q.rd;
   assign cmt_rd_data   = pl_q.rd_data;
   assign cmt_mem_we    = pl_q.mem_we;
   assign cmt_mem_addr  = pl_q.mem_addr;
   assign cmt_mem_wdata = pl_q.mem_wdata;
   assign cmt_trap      = pl_q.trap;
   assign cmt_priv      = priv_q;
   assign busy          = (state_q == S_ISSUE) || (state_q == S_GAP);
   assign done          = done_q;
   assign commit_count  = cnt_q;

endmodule

// File: tb/tb_commit_trace_player.sv
// Directed bench for commit_trace_player: fixed record table, hand-derived
// cycle-by-cycle expectations for playback, stalls, gaps, looping, abort and reset.
module tb_commit_trace_player;

   localparam int XLEN  = 64;
   localparam int DEPTH = 16;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int GAP_W = 4;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             ld_we;
   logic [IDX_W-1:0] ld_idx;
   logic [XLEN-1:0]  ld_pc;
   logic [31:0]      ld_instr;
   logic [4:0]       ld_rd;
   logic [XLEN-1:0]  ld_rd_data;
   logic             ld_mem_we;
   logic [XLEN-1:0]  ld_mem_addr;
   logic [XLEN-1:0]  ld_mem_wdata;
   logic             ld_trap;
   logic [IDX_W:0]   num_entries;
   logic [GAP_W-1:0] gap_cycles;
   logic             loop_en;
   logic [1:0]       priv_mode;
   logic             start;
   logic             abort;
   logic             cmt_valid;
   logic             cmt_ready;
   logic [XLEN-1:0]  cmt_pc;
   logic [31:0]      cmt_instr;
   logic [4:0]       cmt_rd_addr;
   logic [XLEN-1:0]  cmt_rd_data;
   logic             cmt_mem_we;
   logic [XLEN-1:0]  cmt_mem_addr;
   logic [XLEN-1:0]  cmt_mem_wdata;
   logic             cmt_trap;
   logic [1:0]       cmt_priv;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] commit_count;

   commit_trace_player #(
      .XLEN(XLEN), .DEPTH(DEPTH), .IDX_W(IDX_W), .GAP_W(GAP_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .ld_we(ld_we), .ld_idx(ld_idx), .ld_pc(ld_pc), .ld_instr(ld_instr),
      .ld_rd(ld_rd), .ld_rd_data(ld_rd_data), .ld_mem_we(ld_mem_we),
      .ld_mem_addr(ld_mem_addr), .ld_mem_wdata(ld_mem_wdata), .ld_trap(ld_trap),
      .num_entries(num_entries), .gap_cycles(gap_cycles), .loop_en(loop_en),
      .priv_mode(priv_mode), .start(start), .abort(abort),
      .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc),
      .cmt_instr(cmt_instr), .cmt_rd_addr(cmt_rd_addr), .cmt_rd_data(cmt_rd_data),
      .cmt_mem_we(cmt_mem_we), .cmt_mem_addr(cmt_mem_addr),
      .cmt_mem_wdata(cmt_mem_wdata), .cmt_trap(cmt_trap), .cmt_priv(cmt_priv),
      .busy(busy), .done(done), .commit_count(commit_count)
   );

   always #5 clk = ~clk;

   logic [XLEN-1:0] e_pc    [DEPTH];
   logic [31:0]     e_instr [DEPTH];
   logic [4:0]      e_rd    [DEPTH];
   logic [XLEN-1:0] e_data  [DEPTH];
   logic            e_we    [DEPTH];
   logic [XLEN-1:0] e_addr  [DEPTH];
   logic [XLEN-1:0] e_wdata [DEPTH];
   logic            e_trap  [DEPTH];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rec(input string tag, input int i);
      chk({tag, " valid"}, cmt_valid, 1'b1);
      chk({tag, " pc"}, cmt_pc, e_pc[i]);
      chk({tag, " instr"}, cmt_instr, e_instr[i]);
      chk({tag, " rd"}, cmt_rd_addr, e_rd[i]);
      chk({tag, " rd_data"}, cmt_rd_data, e_data[i]);
      chk({tag, " mem_we"}, cmt_mem_we, e_we[i]);
      chk({tag, " mem_addr"}, cmt_mem_addr, e_we[i] ? e_addr[i] : '0);
      chk({tag, " mem_wdata"}, cmt_mem_wdata, e_we[i] ? e_wdata[i] : '0);
      chk({tag, " trap"}, cmt_trap, e_trap[i]);
   endtask

   task automatic set_cfg(input int n, input int g, input logic lp, input logic [1:0] pv);
      num_entries = (IDX_W+1)'(n);
      gap_cycles  = GAP_W'(g);
      loop_en     = lp;
      priv_mode   = pv;
   endtask

   // Pulse start for one edge; the first record is visible right after that edge.
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         e_pc[i]    = 64'h1000 + 64'(4 * i);
         e_instr[i] = 32'h0000_0013 + 32'(i << 7);
         e_rd[i]    = 5'(i + 1);
         e_data[i]  = 64'(19 + i);
         e_we[i]    = ((i % 4) == 2);
         e_addr[i]  = 64'h2000 + 64'(8 * i);
         e_wdata[i] = 64'hA5A5_0000 + 64'(i);
         e_trap[i]  = (i == 2) || (i == 7);
      end
      e_instr[0] = 32'h0130_0093;
      e_instr[1] = 32'h0010_8113;
      e_instr[2] = 32'h0020_9193;

      rst = 1'b1; ld_we = 1'b0; ld_idx = '0; ld_pc = '0; ld_instr = '0; ld_rd = '0;
      ld_rd_data = '0; ld_mem_we = 1'b0; ld_mem_addr = '0; ld_mem_wdata = '0;
      ld_trap = 1'b0; start = 1'b0; abort = 1'b0; cmt_ready = 1'b1;
      set_cfg(0, 0, 1'b0, 2'b00);
      tick();
      tick();
      chk("rst valid", cmt_valid, 1'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
      chk("rst count", commit_count, '0);
      chk("rst pc", cmt_pc, '0);
      chk("rst priv", cmt_priv, 2'b00);
      rst = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         ld_we = 1'b1; ld_idx = IDX_W'(i); ld_pc = e_pc[i]; ld_instr = e_instr[i];
         ld_rd = e_rd[i]; ld_rd_data = e_data[i]; ld_mem_we = e_we[i];
         ld_mem_addr = e_addr[i]; ld_mem_wdata = e_wdata[i]; ld_trap = e_trap[i];
         tick();
      end
      ld_we = 1'b0;
      chk("load idle valid", cmt_valid, 1'b0);

      // 1: three back-to-back commits at full ready
      set_cfg(3, 0, 1'b0, 2'b11);
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         chk_rec($sformatf("t1 rec%0d", k), k);
         chk($sformatf("t1 busy%0d", k), busy, 1'b1);
         chk($sformatf("t1 cnt%0d", k), commit_count, 32'(k));
         tick();
      end
      chk("t1 priv", cmt_priv, 2'b11);
      chk("t1 end valid", cmt_valid, 1'b0);
      chk("t1 done", done, 1'b1);
      chk("t1 count", commit_count, 32'd3);
      chk("t1 busy", busy, 1'b0);

      // 2: four stall cycles on the second record; start while busy is ignored
      set_cfg(3, 0, 1'b0, 2'b01);
      pulse_start();
      chk("t2 done cleared", done, 1'b0);
      chk("t2 count cleared", commit_count, 32'd0);
      chk_rec("t2 rec0", 0);
      tick();
      chk_rec("t2 rec1", 1);
      cmt_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         if (s == 1) start = 1'b1;
         tick();
         start = 1'b0;
         chk($sformatf("t2 stall%0d valid", s), cmt_valid, 1'b1);
         chk($sformatf("t2 stall%0d pc", s), cmt_pc, 64'h1004);
         chk($sformatf("t2 stall%0d cnt", s), commit_count, 32'd1);
      end
      cmt_ready = 1'b1;
      tick();
      chk_rec("t2 rec2", 2);
      chk("t2 cnt after stall", commit_count, 32'd2);
      tick();
      chk("t2 done", done, 1'b1);
      chk("t2 count", commit_count, 32'd3);
      chk("t2 priv", cmt_priv, 2'b01);

      // 3: two-cycle gap gives 1,0,0,1,0,0,1
      set_cfg(3, 2, 1'b0, 2'b00);
      pulse_start();
      for (int c = 0; c < 7; c++) begin
         chk($sformatf("t3 valid c%0d", c), cmt_valid, (c % 3) == 0);
         chk($sformatf("t3 busy c%0d", c), busy, 1'b1);
         if ((c % 3) == 0) chk($sformatf("t3 pc c%0d", c), cmt_pc, e_pc[c / 3]);
         tick();
      end
      chk("t3 end valid", cmt_valid, 1'b0);
      chk("t3 done", done, 1'b1);
      chk("t3 count", commit_count, 32'd3);

      // 4: loop over two entries, abort coincident with the tenth handshake
      set_cfg(2, 0, 1'b1, 2'b00);
      pulse_start();
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("t4 pc%0d", k), cmt_pc, (k % 2 == 0) ? 64'h1000 : 64'h1004);
         chk($sformatf("t4 cnt%0d", k), commit_count, 32'(k));
         if (k == 9) abort = 1'b1;
         tick();
      end
      abort = 1'b0;
      chk("t4 abort valid", cmt_valid, 1'b0);
      chk("t4 abort busy", busy, 1'b0);
      chk("t4 abort done", done, 1'b0);
      chk("t4 abort count", commit_count, 32'd10);
      tick();
      chk("t4 idle valid", cmt_valid, 1'b0);

      // 5: zero-length start ignored; oversize length clamps to DEPTH; writes ignored while busy
      set_cfg(0, 0, 1'b0, 2'b00);
      pulse_start();
      tick();
      chk("t5 zero valid", cmt_valid, 1'b0);
      chk("t5 zero busy", busy, 1'b0);
      chk("t5 zero count", commit_count, 32'd10);
      set_cfg(DEPTH + 5, 0, 1'b0, 2'b10);
      pulse_start();
      for (int k = 0; k < DEPTH; k++) begin
         chk_rec($sformatf("t5 rec%0d", k), k);
         if (k == 3) begin
            ld_we = 1'b1; ld_idx = IDX_W'(5); ld_pc = 64'hBAD0; ld_instr = 32'hDEAD_BEEF;
            ld_rd = 5'd31; ld_rd_data = 64'hBAD1; ld_mem_we = 1'b1; ld_trap = 1'b1;
         end else begin
            ld_we = 1'b0;
         end
         tick();
      end
      ld_we = 1'b0;
      chk("t5 valid end", cmt_valid, 1'b0);
      chk("t5 done", done, 1'b1);
      chk("t5 count", commit_count, 32'(DEPTH));

      // 6: reset while in GAP, then replay with the table intact
      set_cfg(3, 3, 1'b0, 2'b00);
      pulse_start();
      chk_rec("t6 rec0", 0);
      tick();
      chk("t6 gap valid", cmt_valid, 1'b0);
      chk("t6 gap busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6 rst valid", cmt_valid, 1'b0);
      chk("t6 rst busy", busy, 1'b0);
      chk("t6 rst count", commit_count, 32'd0);
      chk("t6 rst done", done, 1'b0);
      chk("t6 rst pc", cmt_pc, '0);
      tick();
      chk("t6 idle valid", cmt_valid, 1'b0);
      set_cfg(3, 0, 1'b0, 2'b00);
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         chk_rec($sformatf("t6 replay%0d", k), k);
         tick();
      end
      chk("t6 done", done, 1'b1);
      chk("t6 count", commit_count, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
